cache_port_arbiter: RTL

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

---
 rtl/cache_port_arbiter_if.sv | 31 +++
 rtl/cache_port_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: one request/response handshake channel.
// Signals:
//   req, reqdata, reqtag, reqcyc  -- request address, write data, tag and valid (master -> slave)
//   reqack                        -- request accepted (slave -> master)
//   resp, resptag, respcyc        -- response data, tag and valid (slave -> master)
//   respack                       -- response consumed (master -> slave)
// The master modport issues requests; the slave modport serves them.
interface cache_port_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    logic [DATA_WIDTH-1:0] req;
    logic [DATA_WIDTH-1:0] reqdata;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic [TAG_WIDTH-1:0]  resptag;
    logic                  reqcyc;
    logic                  reqack;
    logic                  respcyc;
    logic                  respack;

    modport master (
        output req, reqdata, reqtag, reqcyc, respack,
        input  reqack, resp, resptag, respcyc
    );

    modport slave (
        input  req, reqdata, reqtag, reqcyc, respack,
        output reqack, resp, resptag, respcyc
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin arbiter merging instruction and data request
// streams onto one cache port and routing responses back by tag source bit.
// Ports:
//   clk    -- clock, all state on rising edge
//   reset  -- asynchronous active-low reset
//   i_bus  -- instruction-side channel (slave: arbiter accepts requests, returns responses)
//   d_bus  -- data-side channel (slave)
//   m_bus  -- cache-facing channel (master: arbiter issues requests, consumes responses)
module cache_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
) (
    input  logic                        clk,
    input  logic                        reset,
    cache_port_arbiter_if.slave         i_bus,
    cache_port_arbiter_if.slave         d_bus,
    cache_port_arbiter_if.master        m_bus
);
    // Tag bit carrying the originating source: 0 = instruction, 1 = data.
    localparam int SRC = TAG_WIDTH - 6;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d;
    // Index 0 = instruction side, index 1 = data side.
    logic [1:0]            out_q, out_d;
    logic [1:0]            ack_q, ack_d;
    logic [1:0]            bv_q, bv_d;
    logic [DATA_WIDTH-1:0] req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [DATA_WIDTH-1:0] ibuf_q, ibuf_d;
    logic [DATA_WIDTH-1:0] dbuf_q, dbuf_d;
    logic [TAG_WIDTH-1:0]  itag_q, itag_d;
    logic [TAG_WIDTH-1:0]  dtag_q, dtag_d;
    logic                  i_elig, d_elig, grant_i, grant_d, resp_side, resp_fire;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        out_d    = out_q;
        ack_d    = 2'b00;
        bv_d     = bv_q;
        req_d    = req_q;
        data_d   = data_q;
        tag_d    = tag_q;
        ibuf_d   = ibuf_q;
        dbuf_d   = dbuf_q;
        itag_d   = itag_q;
        dtag_d   = dtag_q;
        i_elig   = i_bus.reqcyc & ~out_q[0];
        d_elig   = d_bus.reqcyc & ~out_q[1];
        // On a tie the side that did not win last time is granted.
        grant_d  = (state_q == IDLE) && d_elig && (!i_elig || !last_d_q);
        grant_i  = (state_q == IDLE) && i_elig && !grant_d;
        resp_side = m_bus.resptag[SRC];
        // Accept only into an empty buffer; reset gating keeps the ack low during reset.
        resp_fire = reset & m_bus.respcyc & ~bv_q[resp_side];
        if (grant_i || grant_d) begin
            state_d    = grant_d ? BUSY_D : BUSY_I;
            last_d_d   = grant_d;
            ack_d      = {grant_d, grant_i};
            out_d      = out_q | {grant_d, grant_i};
            req_d      = grant_d ? d_bus.req : i_bus.req;
            data_d     = grant_d ? d_bus.reqdata : i_bus.reqdata;
            tag_d      = grant_d ? d_bus.reqtag : i_bus.reqtag;
            tag_d[SRC] = grant_d;
        end else if (state_q != IDLE && m_bus.reqack) begin
            state_d = IDLE;
        end
        if (bv_q[0] && i_bus.respack) begin
            bv_d[0]  = 1'b0;
            out_d[0] = 1'b0;
        end
        if (bv_q[1] && d_bus.respack) begin
            bv_d[1]  = 1'b0;
            out_d[1] = 1'b0;
        end
        // A response with nothing outstanding for its side is acked and dropped.
        if (resp_fire && out_q[resp_side]) begin
            bv_d[resp_side] = 1'b1;
            if (resp_side) begin
                dbuf_d = m_bus.resp;
                dtag_d = m_bus.resptag;
            end else begin
                ibuf_d = m_bus.resp;
                itag_d = m_bus.resptag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            out_q    <= '0;
            ack_q    <= '0;
            bv_q     <= '0;
            req_q    <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            ibuf_q   <= '0;
            dbuf_q   <= '0;
            itag_q   <= '0;
            dtag_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            out_q    <= out_d;
            ack_q    <= ack_d;
            bv_q     <= bv_d;
            req_q    <= req_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            ibuf_q   <= ibuf_d;
            dbuf_q   <= dbuf_d;
            itag_q   <= itag_d;
            dtag_q   <= dtag_d;
        end
    end

    assign i_bus.reqack   = ack_q[0];
    assign d_bus.reqack   = ack_q[1];
    assign i_bus.respcyc  = bv_q[0];
    assign i_bus.resp     = ibuf_q;
    assign i_bus.resptag  = itag_q;
    assign d_bus.respcyc  = bv_q[1];
    assign d_bus.resp     = dbuf_q;
    assign d_bus.resptag  = dtag_q;
    assign m_bus.req      = req_q;
    assign m_bus.reqdata  = data_q;
    assign m_bus.reqtag   = tag_q;
    assign m_bus.reqcyc   = state_q != IDLE;
    assign m_bus.respack  = resp_fire;
endmodule
